// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and enums for the regfile writeback arbiter.
//   DATA_W_DEF / ADDR_W_DEF : default data / register-select widths
//   ZERO_ADDR               : address of the hardwired zero register
//   req_id_e                : requester ids, also used as hold-array indices
//   pri_e                   : round-robin pointer states
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int ZERO_ADDR  = 0;
    localparam int NUM_REQ    = 2;

    typedef enum logic { REQ_A = 1'b0, REQ_B = 1'b1 } req_id_e;
    typedef enum logic { PRI_A = 1'b0, PRI_B = 1'b1 } pri_e;
endpackage

// File: rtl/regfile_wb_hold.sv
// regfile_wb_hold: one-entry valid/addr/data holding register.
//   clk, rst          : clock, synchronous active-high reset
//   load              : capture in_addr/in_data and mark valid
//   clear             : drop the entry (load wins when both are set)
//   in_addr, in_data  : entry to capture
//   valid, addr, data : current entry
module regfile_wb_hold #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            addr  <= '0;
            data  <= '0;
        end else if (load) begin
            // a reload on the grant edge keeps the entry full
            valid <= 1'b1;
            addr  <= in_addr;
            data  <= in_data;
        end else if (clear) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the regfile write port between requester A
// (ALU result) and requester B (load/sbus return). Each requester feeds a
// one-entry hold; a round-robin arbiter issues one registered write per cycle.
//   clk, rst                          : clock, synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data     : requester A handshake
//   b_valid/b_ready/b_addr/b_data     : requester B handshake
//   rf_we/rf_write_select/rf_sbus_in  : registered regfile write port
//   rd_addr/rd_hazard                 : decode hazard query (combinational)
//   wr_count                          : saturating committed-write count
//   fwd_valid/fwd_data                : in-flight write forward, present only
//                                       when REGFILE_WB_FWD_EN is defined
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_write_select,
    output logic [DATA_W-1:0] rf_sbus_in,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_hazard,
`ifdef REGFILE_WB_FWD_EN
    output logic              fwd_valid,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [CNT_W-1:0]  wr_count
);
    logic [NUM_REQ-1:0]             in_valid, occ, grant, ready, load;
    logic [NUM_REQ-1:0][ADDR_W-1:0] in_addr, h_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] in_data, h_data;

    pri_e        pri_q, pri_d;
    req_id_e     gnt_sel;
    logic        gnt_any, gnt_zero, rd_zero;
    logic [ADDR_W-1:0] gnt_addr;

    assign in_valid = {b_valid, a_valid};
    assign in_addr  = {b_addr, a_addr};
    assign in_data  = {b_data, a_data};

    // a hold accepts when empty or when it is being drained this cycle
    assign ready   = ~occ | grant;
    assign load    = in_valid & ready;
    assign a_ready = ready[REQ_A];
    assign b_ready = ready[REQ_B];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
        regfile_wb_hold #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_hold (
            .clk     (clk),
            .rst     (rst),
            .load    (load[i]),
            .clear   (grant[i]),
            .in_addr (in_addr[i]),
            .in_data (in_data[i]),
            .valid   (occ[i]),
            .addr    (h_addr[i]),
            .data    (h_data[i])
        );
    end

    // pointer only breaks ties; a lone occupied hold always wins
    always_comb begin
        grant = '0;
        if (occ[REQ_A] && (!occ[REQ_B] || pri_q == PRI_A))
            grant[REQ_A] = 1'b1;
        else if (occ[REQ_B])
            grant[REQ_B] = 1'b1;
    end

    assign gnt_any  = |grant;
    assign gnt_sel  = grant[REQ_B] ? REQ_B : REQ_A;
    assign gnt_addr = h_addr[gnt_sel];
    // zero-register writes still take the slot but never reach the regfile
    assign gnt_zero = (ZERO_REG != 0) && (gnt_addr == ADDR_W'(ZERO_ADDR));
    assign rd_zero  = (ZERO_REG != 0) && (rd_addr == ADDR_W'(ZERO_ADDR));

    always_ff @(posedge clk) begin
        if (rst) pri_q <= PRI_A;
        else     pri_q <= pri_d;
    end

    always_comb begin
        pri_d = pri_q;
        case (pri_q)
            PRI_A: if (grant[REQ_A]) pri_d = PRI_B;
                   else if (grant[REQ_B]) pri_d = PRI_A;
            PRI_B: if (grant[REQ_B]) pri_d = PRI_A;
                   else if (grant[REQ_A]) pri_d = PRI_B;
            default: pri_d = PRI_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we           <= 1'b0;
            rf_write_select <= '0;
            rf_sbus_in      <= '0;
            wr_count        <= '0;
        end else if (gnt_any && !gnt_zero) begin
            rf_we           <= 1'b1;
            rf_write_select <= gnt_addr;
            rf_sbus_in      <= h_data[gnt_sel];
            if (wr_count != '1)
                wr_count <= wr_count + 1'b1;
        end else begin
            rf_we <= 1'b0;
        end
    end

    always_comb begin
        rd_hazard = 1'b0;
        if (!rd_zero)
            rd_hazard = (occ[REQ_A] && h_addr[REQ_A] == rd_addr) ||
                        (occ[REQ_B] && h_addr[REQ_B] == rd_addr) ||
                        (rf_we && rf_write_select == rd_addr);
    end

`ifdef REGFILE_WB_FWD_EN
    assign fwd_valid = rf_we && (rf_write_select == rd_addr) && !rd_zero;
    assign fwd_data  = rf_sbus_in;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid, b_valid;
    logic              a_ready, b_ready;
    logic [ADDR_W-1:0] a_addr, b_addr, rd_addr;
    logic [DATA_W-1:0] a_data, b_data;
    logic              rf_we, rd_hazard;
    logic [ADDR_W-1:0] rf_write_select;
    logic [DATA_W-1:0] rf_sbus_in;
    logic [CNT_W-1:0]  wr_count;
`ifdef REGFILE_WB_FWD_EN
    logic              fwd_valid;
    logic [DATA_W-1:0] fwd_data;
`endif

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1), .CNT_W(CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .a_valid         (a_valid),
        .a_ready         (a_ready),
        .a_addr          (a_addr),
        .a_data          (a_data),
        .b_valid         (b_valid),
        .b_ready         (b_ready),
        .b_addr          (b_addr),
        .b_data          (b_data),
        .rf_we           (rf_we),
        .rf_write_select (rf_write_select),
        .rf_sbus_in      (rf_sbus_in),
        .rd_addr         (rd_addr),
        .rd_hazard       (rd_hazard),
`ifdef REGFILE_WB_FWD_EN
        .fwd_valid       (fwd_valid),
        .fwd_data        (fwd_data),
`endif
        .wr_count        (wr_count)
    );

    // advance one edge, then settle so outputs are read away from the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid = 0; b_valid = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; rd_addr = '0;
        do_reset();
        total++; if (rf_we !== 1'b0) $display("FAIL reset_we got %b exp 0", rf_we); else pass_cnt++;
        total++; if (rf_write_select !== '0) $display("FAIL reset_sel got %0d exp 0", rf_write_select); else pass_cnt++;
        total++; if (rf_sbus_in !== '0) $display("FAIL reset_data got %h exp 0", rf_sbus_in); else pass_cnt++;
        total++; if (wr_count !== '0) $display("FAIL reset_cnt got %0d exp 0", wr_count); else pass_cnt++;
        total++; if ({a_ready, b_ready} !== 2'b11) $display("FAIL reset_ready got %b exp 11", {a_ready, b_ready}); else pass_cnt++;
    endtask

    task automatic test_single_write();
        do_reset();
        a_valid = 1; a_addr = 5'd3; a_data = 32'hDEADBEEF; rd_addr = 5'd3;
        total++; if (a_ready !== 1'b1) $display("FAIL single_ready got %b exp 1", a_ready); else pass_cnt++;
        tick();                     // handshake
        a_valid = 0; a_data = 32'h0;
        total++; if (rd_hazard !== 1'b1) $display("FAIL single_hold_hazard got %b exp 1", rd_hazard); else pass_cnt++;
        total++; if (rf_we !== 1'b0) $display("FAIL single_we_early got %b exp 0", rf_we); else pass_cnt++;
        tick();                     // issue
        total++; if (rf_we !== 1'b1) $display("FAIL single_we got %b exp 1", rf_we); else pass_cnt++;
        total++; if (rf_write_select !== 5'd3) $display("FAIL single_sel got %0d exp 3", rf_write_select); else pass_cnt++;
        total++; if (rf_sbus_in !== 32'hDEADBEEF) $display("FAIL single_data got %h exp deadbeef", rf_sbus_in); else pass_cnt++;
        total++; if (wr_count !== 4'd1) $display("FAIL single_cnt got %0d exp 1", wr_count); else pass_cnt++;
        tick();
        total++; if (rf_we !== 1'b0) $display("FAIL single_we_drop got %b exp 0", rf_we); else pass_cnt++;
        total++; if (rf_write_select !== 5'd3) $display("FAIL single_sel_keep got %0d exp 3", rf_write_select); else pass_cnt++;
    endtask

    task automatic test_round_robin();
        logic [ADDR_W-1:0] exp_sel;
        logic [DATA_W-1:0] exp_data;
        logic              exp_ar;
        do_reset();
        a_valid = 1; a_addr = 5'd1; a_data = 32'h11111111;
        b_valid = 1; b_addr = 5'd2; b_data = 32'h22222222;
        tick();                     // both holds loaded, pointer at A
        total++; if ({a_ready, b_ready} !== 2'b10) $display("FAIL rr_ready0 got %b exp 10", {a_ready, b_ready}); else pass_cnt++;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_sel  = (k % 2 == 1) ? 5'd1 : 5'd2;
            exp_data = (k % 2 == 1) ? 32'h11111111 : 32'h22222222;
            exp_ar   = (k % 2 == 0);
            total++; if (rf_we !== 1'b1 || rf_write_select !== exp_sel || rf_sbus_in !== exp_data)
                $display("FAIL rr_issue%0d got we=%b sel=%0d data=%h exp we=1 sel=%0d data=%h", k, rf_we, rf_write_select, rf_sbus_in, exp_sel, exp_data);
            else pass_cnt++;
            total++; if ({a_ready, b_ready} !== {exp_ar, ~exp_ar})
                $display("FAIL rr_ready%0d got %b exp %b", k, {a_ready, b_ready}, {exp_ar, ~exp_ar});
            else pass_cnt++;
            total++; if (wr_count !== CNT_W'(k)) $display("FAIL rr_cnt%0d got %0d exp %0d", k, wr_count, k); else pass_cnt++;
        end
        a_valid = 0; b_valid = 0;
    endtask

    task automatic test_zero_reg();
        do_reset();
        a_valid = 1; a_addr = 5'd0; a_data = 32'h12345678; rd_addr = 5'd0;
        tick();
        a_valid = 0;
        total++; if (rd_hazard !== 1'b0) $display("FAIL zero_hazard got %b exp 0", rd_hazard); else pass_cnt++;
        tick();                     // granted but dropped
        total++; if (rf_we !== 1'b0) $display("FAIL zero_we got %b exp 0", rf_we); else pass_cnt++;
        total++; if (wr_count !== 4'd0) $display("FAIL zero_cnt got %0d exp 0", wr_count); else pass_cnt++;
        total++; if (a_ready !== 1'b1) $display("FAIL zero_drained got %b exp 1", a_ready); else pass_cnt++;
        // pointer advanced past A, so B wins the next tie
        a_valid = 1; a_addr = 5'd4; a_data = 32'hAAAA0004;
        b_valid = 1; b_addr = 5'd5; b_data = 32'hBBBB0005;
        tick();
        a_valid = 0; b_valid = 0;
        tick();
        total++; if (rf_write_select !== 5'd5 || rf_we !== 1'b1)
            $display("FAIL zero_ptr_adv got we=%b sel=%0d exp we=1 sel=5", rf_we, rf_write_select);
        else pass_cnt++;
        tick();
        total++; if (rf_write_select !== 5'd4 || rf_sbus_in !== 32'hAAAA0004)
            $display("FAIL zero_ptr_next got sel=%0d data=%h exp sel=4 data=aaaa0004", rf_write_select, rf_sbus_in);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_hazard();
        do_reset();
        a_valid = 1; a_addr = 5'd7; a_data = 32'h00000777; rd_addr = 5'd7;
        tick();
        a_valid = 0;
        total++; if (rd_hazard !== 1'b1) $display("FAIL haz_hold got %b exp 1", rd_hazard); else pass_cnt++;
        rd_addr = 5'd8; #1;
        total++; if (rd_hazard !== 1'b0) $display("FAIL haz_other got %b exp 0", rd_hazard); else pass_cnt++;
        rd_addr = 5'd7;
        tick();                     // in flight on the write port
        total++; if (rd_hazard !== 1'b1) $display("FAIL haz_issue got %b exp 1", rd_hazard); else pass_cnt++;
        tick();
        total++; if (rd_hazard !== 1'b0) $display("FAIL haz_done got %b exp 0", rd_hazard); else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        do_reset();
        a_valid = 1; a_addr = 5'd1; a_data = 32'h1;
        b_valid = 1; b_addr = 5'd2; b_data = 32'h2;
        tick();                     // both holds full
        a_valid = 0; b_valid = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_addr = 5'd2; #1;
        total++; if (rf_we !== 1'b0) $display("FAIL rstmid_we got %b exp 0", rf_we); else pass_cnt++;
        total++; if ({a_ready, b_ready} !== 2'b11) $display("FAIL rstmid_ready got %b exp 11", {a_ready, b_ready}); else pass_cnt++;
        total++; if (wr_count !== 4'd0) $display("FAIL rstmid_cnt got %0d exp 0", wr_count); else pass_cnt++;
        total++; if (rd_hazard !== 1'b0) $display("FAIL rstmid_hazard got %b exp 0", rd_hazard); else pass_cnt++;
        tick();
        total++; if (rf_we !== 1'b0) $display("FAIL rstmid_stale1 got %b exp 0", rf_we); else pass_cnt++;
        tick();
        total++; if (rf_we !== 1'b0) $display("FAIL rstmid_stale2 got %b exp 0", rf_we); else pass_cnt++;
    endtask

    task automatic test_saturate();
        do_reset();
        a_valid = 1; a_addr = 5'd6; a_data = 32'h66;
        tick();                     // first handshake
        for (int k = 1; k <= 18; k++) begin
            tick();
            if (k == 14 || k == 15 || k == 18) begin
                total++; if (wr_count !== CNT_W'((k > 15) ? 15 : k))
                    $display("FAIL sat_cnt%0d got %0d exp %0d", k, wr_count, (k > 15) ? 15 : k);
                else pass_cnt++;
            end
        end
        total++; if (a_ready !== 1'b1 || rf_we !== 1'b1)
            $display("FAIL sat_stream got ready=%b we=%b exp 1 1", a_ready, rf_we);
        else pass_cnt++;
        a_valid = 0;
        tick();
    endtask

`ifdef REGFILE_WB_FWD_EN
    task automatic test_forward();
        do_reset();
        b_valid = 1; b_addr = 5'd9; b_data = 32'hCAFEF00D; rd_addr = 5'd9;
        tick();
        b_valid = 0;
        total++; if (fwd_valid !== 1'b0) $display("FAIL fwd_early got %b exp 0", fwd_valid); else pass_cnt++;
        tick();
        total++; if (fwd_valid !== 1'b1 || fwd_data !== 32'hCAFEF00D)
            $display("FAIL fwd_hit got v=%b d=%h exp v=1 d=cafef00d", fwd_valid, fwd_data);
        else pass_cnt++;
        rd_addr = 5'd10; #1;
        total++; if (fwd_valid !== 1'b0) $display("FAIL fwd_miss got %b exp 0", fwd_valid); else pass_cnt++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_round_robin();
        test_zero_reg();
        test_hazard();
        test_reset_midop();
        test_saturate();
`ifdef REGFILE_WB_FWD_EN
        test_forward();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
